// File: rtl/serial_cmd_frame_decoder.sv
// Byte-level parser for FF FF 00 LEN PAYLOAD EE EE frames with valid/ack handoff and error codes.
// Optional inter-byte timeout is compiled in with `define SERIAL_CMD_DECODER_TIMEOUT_EN.
module serial_cmd_frame_decoder #(
    parameter int unsigned MAX_PAYLOAD_LEN = 8,
    parameter int unsigned TIMEOUT_CYCLES  = 5_000_000
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [7:0]                   rx_data,
    input  logic                         rx_valid,
    output logic                         frame_valid,
    input  logic                         frame_ack,
    output logic [7:0]                   payload_len,
    output logic [8*MAX_PAYLOAD_LEN-1:0] payload,
    output logic                         frame_error,
    output logic [2:0]                   error_code,
    output logic                         busy
);
    localparam int unsigned PW = 8 * MAX_PAYLOAD_LEN;

    localparam logic [2:0] ERR_LEN     = 3'd1;
    localparam logic [2:0] ERR_SPACE   = 3'd2;
    localparam logic [2:0] ERR_EOF     = 3'd3;
    localparam logic [2:0] ERR_TIMEOUT = 3'd4;
    localparam logic [2:0] ERR_OVERRUN = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE, S_SOF2, S_SPACE, S_LEN, S_PAYLOAD, S_EOF1, S_EOF2, S_HOLD
    } state_e;

    if (MAX_PAYLOAD_LEN < 1 || MAX_PAYLOAD_LEN > 255 || TIMEOUT_CYCLES < 2) begin : g_param_check
        $error("serial_cmd_frame_decoder: parameter out of range");
    end

    state_e          state_q, state_d;
    logic [7:0]      idx_q, idx_d;
    logic [7:0]      payload_len_q, payload_len_d;
    logic [PW-1:0]   payload_q, payload_d;
    logic            frame_valid_q, frame_valid_d;
    logic            frame_error_q, frame_error_d;
    logic [2:0]      error_code_q, error_code_d;
    logic            busy_q, busy_d;
    logic            tmo_hit;

`ifdef SERIAL_CMD_DECODER_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES);

    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             timed;

    // Counts idle cycles inside a partial frame; any strobe restarts it.
    always_comb begin
        timed     = (state_q != S_IDLE) && (state_q != S_HOLD);
        tmo_hit   = timed && !rx_valid && (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1));
        tmo_cnt_d = '0;
        if (timed && !rx_valid && !tmo_hit) begin
            tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) tmo_cnt_q <= '0;
        else        tmo_cnt_q <= tmo_cnt_d;
    end
`else
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        payload_len_d = payload_len_q;
        payload_d     = payload_q;
        frame_error_d = 1'b0;
        error_code_d  = error_code_q;

        if (state_q == S_HOLD) begin
            if (rx_valid) begin
                frame_error_d = 1'b1;
                error_code_d  = ERR_OVERRUN;
            end
            if (frame_ack) state_d = S_IDLE;
        end else if (tmo_hit) begin
            state_d       = S_IDLE;
            frame_error_d = 1'b1;
            error_code_d  = ERR_TIMEOUT;
        end else if (rx_valid) begin
            case (state_q)
                S_IDLE: if (rx_data == 8'hFF) state_d = S_SOF2;
                S_SOF2: state_d = (rx_data == 8'hFF) ? S_SPACE : S_IDLE;
                S_SPACE: begin
                    if (rx_data == 8'h00) begin
                        state_d = S_LEN;
                    end else begin
                        state_d       = S_IDLE;
                        frame_error_d = 1'b1;
                        error_code_d  = ERR_SPACE;
                    end
                end
                S_LEN: begin
                    if (rx_data == 8'd0 || rx_data > 8'(MAX_PAYLOAD_LEN)) begin
                        state_d       = S_IDLE;
                        frame_error_d = 1'b1;
                        error_code_d  = ERR_LEN;
                    end else begin
                        payload_len_d = rx_data;
                        idx_d         = 8'd0;
                        payload_d     = '0;
                        state_d       = S_PAYLOAD;
                    end
                end
                S_PAYLOAD: begin
                    for (int i = 0; i < int'(MAX_PAYLOAD_LEN); i++) begin
                        if (idx_q == 8'(i)) payload_d[8*i +: 8] = rx_data;
                    end
                    idx_d = idx_q + 8'd1;
                    if (idx_q == payload_len_q - 8'd1) state_d = S_EOF1;
                end
                S_EOF1, S_EOF2: begin
                    if (rx_data == 8'hEE) begin
                        state_d = (state_q == S_EOF1) ? S_EOF2 : S_HOLD;
                    end else begin
                        state_d       = S_IDLE;
                        frame_error_d = 1'b1;
                        error_code_d  = ERR_EOF;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        frame_valid_d = (state_d == S_HOLD);
        busy_d        = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            idx_q         <= 8'd0;
            payload_len_q <= 8'd0;
            payload_q     <= '0;
            frame_valid_q <= 1'b0;
            frame_error_q <= 1'b0;
            error_code_q  <= 3'd0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            payload_len_q <= payload_len_d;
            payload_q     <= payload_d;
            frame_valid_q <= frame_valid_d;
            frame_error_q <= frame_error_d;
            error_code_q  <= error_code_d;
            busy_q        <= busy_d;
        end
    end

    assign frame_valid = frame_valid_q;
    assign payload_len = payload_len_q;
    assign payload     = payload_q;
    assign frame_error = frame_error_q;
    assign error_code  = error_code_q;
    assign busy        = busy_q;
endmodule

// File: tb/tb_serial_cmd_frame_decoder.sv
// Bench for serial_cmd_frame_decoder: directed frames plus random byte streams against a
// position-counting reference model of the frame grammar.
module tb_serial_cmd_frame_decoder;
    localparam int MAXL = 8;
    localparam int TMO  = 100;
`ifdef SERIAL_CMD_DECODER_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [7:0]      rx_data = 8'h00;
    logic            rx_valid = 1'b0;
    logic            frame_ack = 1'b0;
    logic            frame_valid;
    logic [7:0]      payload_len;
    logic [8*MAXL-1:0] payload;
    logic            frame_error;
    logic [2:0]      error_code;
    logic            busy;

    serial_cmd_frame_decoder #(.MAX_PAYLOAD_LEN(MAXL), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
        .frame_valid(frame_valid), .frame_ack(frame_ack), .payload_len(payload_len),
        .payload(payload), .frame_error(frame_error), .error_code(error_code), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: frame position counter over the byte stream.
    int         m_pos;
    int         m_idle;
    bit         m_held;
    logic [7:0] m_len;
    logic [7:0] m_buf [MAXL];
    logic       m_err;
    logic [2:0] m_code;

    logic [7:0] byte_q [$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [63:0] m_payload();
        logic [63:0] r = '0;
        for (int i = 0; i < MAXL; i++) r[8*i +: 8] = m_buf[i];
        return r;
    endfunction

    task automatic m_raise(input logic [2:0] c);
        m_err  = 1'b1;
        m_code = c;
    endtask

    task automatic m_reset();
        m_pos = 0; m_idle = 0; m_held = 0; m_len = 8'd0; m_err = 0; m_code = 3'd0;
        for (int i = 0; i < MAXL; i++) m_buf[i] = 8'h00;
    endtask

    task automatic model_edge(input logic v, input logic [7:0] d, input logic a, input logic r);
        if (!r) begin
            m_reset();
            return;
        end
        m_err = 1'b0;
        if (m_held) begin
            if (v) m_raise(3'd5);
            if (a) m_held = 0;
        end else if (!v) begin
            if (TMO_EN && m_pos != 0) begin
                m_idle++;
                if (m_idle == TMO) begin
                    m_raise(3'd4);
                    m_pos = 0;
                end
            end
        end else begin
            m_idle = 0;
            if (m_pos == 0) begin
                if (d == 8'hFF) m_pos = 1;
            end else if (m_pos == 1) begin
                m_pos = (d == 8'hFF) ? 2 : 0;
            end else if (m_pos == 2) begin
                if (d == 8'h00) m_pos = 3;
                else begin m_raise(3'd2); m_pos = 0; end
            end else if (m_pos == 3) begin
                if (d == 0 || int'(d) > MAXL) begin
                    m_raise(3'd1); m_pos = 0;
                end else begin
                    m_len = d;
                    for (int i = 0; i < MAXL; i++) m_buf[i] = 8'h00;
                    m_pos = 4;
                end
            end else if (m_pos < 4 + int'(m_len)) begin
                m_buf[m_pos-4] = d;
                m_pos++;
            end else if (d != 8'hEE) begin
                m_raise(3'd3); m_pos = 0;
            end else if (m_pos == 4 + int'(m_len)) begin
                m_pos++;
            end else begin
                m_held = 1; m_pos = 0;
            end
        end
        if (m_pos == 0 || m_held) m_idle = 0;
    endtask

    task automatic cmp_all();
        chk("valid", 64'(frame_valid), 64'(m_held));
        chk("len", 64'(payload_len), 64'(m_len));
        chk("payload", payload, m_payload());
        chk("err", 64'(frame_error), 64'(m_err));
        chk("code", 64'(error_code), 64'(m_code));
        chk("busy", 64'(busy), 64'(m_held || m_pos != 0));
    endtask

    task automatic step(input logic v, input logic [7:0] d, input logic a, input logic r);
        rx_valid = v; rx_data = d; frame_ack = a; rst_n = r;
        @(posedge clk);
        model_edge(v, d, a, r);
        #1;
        cmp_all();
    endtask

    task automatic send(input logic [7:0] b);
        step(1'b1, b, 1'b0, 1'b1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, 1'b1);
    endtask

    task automatic ack();
        step(1'b0, 8'h00, 1'b1, 1'b1);
    endtask

    task automatic flush_q();
        while (byte_q.size() > 0) send(byte_q.pop_front());
    endtask

    task automatic push_frame(input int len, input int kind);
        byte_q.push_back(8'hFF); byte_q.push_back(8'hFF);
        byte_q.push_back(kind == 0 ? 8'h5A : 8'h00);
        byte_q.push_back(8'(len));
        for (int i = 0; i < len; i++) byte_q.push_back(8'($urandom));
        byte_q.push_back(kind == 1 ? 8'hEF : 8'hEE);
        byte_q.push_back(kind == 2 ? 8'h00 : 8'hEE);
    endtask

    initial begin
        logic [63:0] held_pl;
        m_reset();
        step(1'b0, 8'h00, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_code", 64'(error_code), 64'd0);

        // Read-register frame, back-to-back.
        byte_q = '{8'hFF, 8'hFF, 8'h00, 8'h02, 8'h02, 8'h03, 8'hEE, 8'hEE};
        flush_q();
        chk("t1_valid", 64'(frame_valid), 64'd1);
        chk("t1_len", 64'(payload_len), 64'd2);
        chk("t1_pl", 64'(payload[15:0]), 64'h0302);
        ack();
        chk("t1_ack", 64'(frame_valid), 64'd0);

        // Length bounds.
        byte_q = '{8'hFF, 8'hFF, 8'h00, 8'h00}; flush_q();
        chk("len0_code", 64'(error_code), 64'd1);
        chk("len0_err", 64'(frame_error), 64'd1);
        byte_q = '{8'hFF, 8'hFF, 8'h00, 8'h09}; flush_q();
        chk("len9_code", 64'(error_code), 64'd1);
        byte_q = '{8'hFF, 8'hFF, 8'h00, 8'h08, 8'h11, 8'h22, 8'h33, 8'h44,
                   8'h55, 8'h66, 8'h77, 8'h88, 8'hEE, 8'hEE};
        flush_q();
        chk("len8_pl", payload, 64'h8877665544332211);
        chk("len8_valid", 64'(frame_valid), 64'd1);
        ack();

        // Corruption then recovery.
        byte_q = '{8'hFF, 8'hFF, 8'h01}; flush_q();
        chk("space_code", 64'(error_code), 64'd2);
        byte_q = '{8'hFF, 8'hFF, 8'h00, 8'h01, 8'h7E, 8'hEE, 8'hEE}; flush_q();
        chk("rec1_pl", 64'(payload[7:0]), 64'h7E);
        ack();
        byte_q = '{8'hFF, 8'hFF, 8'h00, 8'h01, 8'hAA, 8'hEE, 8'h00}; flush_q();
        chk("eof_code", 64'(error_code), 64'd3);
        byte_q = '{8'hFF, 8'hFF, 8'h00, 8'h01, 8'h3C, 8'hEE, 8'hEE}; flush_q();
        chk("rec2_pl", 64'(payload[7:0]), 64'h3C);

        // Overrun while held.
        held_pl = payload;
        for (int i = 0; i < 3; i++) begin
            send(8'(8'hA0 + i));
            chk("ovr_err", 64'(frame_error), 64'd1);
            chk("ovr_code", 64'(error_code), 64'd5);
            chk("ovr_pl", payload, held_pl);
        end
        ack();
        chk("ovr_idle", 64'(busy), 64'd0);
        byte_q = '{8'hFF, 8'hFF, 8'h00, 8'h01, 8'h99, 8'hEE, 8'hEE}; flush_q();
        chk("post_ovr", 64'(payload[7:0]), 64'h99);
        step(1'b1, 8'h42, 1'b1, 1'b1);
        chk("ackovr_code", 64'(error_code), 64'd5);
        chk("ackovr_busy", 64'(busy), 64'd0);

        // Resync through leading garbage.
        byte_q = '{8'h12, 8'hFF, 8'h34, 8'hFF, 8'hFF, 8'h00, 8'h01, 8'h55, 8'hEE, 8'hEE};
        flush_q();
        chk("resync_pl", 64'(payload[7:0]), 64'h55);
        chk("resync_valid", 64'(frame_valid), 64'd1);
        ack();

        // Reset mid-frame.
        byte_q = '{8'hFF, 8'hFF, 8'h00, 8'h03, 8'h01}; flush_q();
        step(1'b0, 8'h00, 1'b0, 1'b0);
        chk("mrst_pl", payload, 64'd0);
        chk("mrst_err", 64'(frame_error), 64'd0);
        chk("mrst_busy", 64'(busy), 64'd0);

        // Inter-byte timeout.
        byte_q = '{8'hFF, 8'hFF, 8'h00}; flush_q();
        idle(TMO);
        if (TMO_EN) begin
            chk("tmo_code", 64'(error_code), 64'd4);
            chk("tmo_busy", 64'(busy), 64'd0);
        end else begin
            chk("tmo_noerr", 64'(error_code), 64'd0);
            chk("tmo_busy", 64'(busy), 64'd1);
        end
        step(1'b0, 8'h00, 1'b0, 1'b0);

        // Random frames, gaps and acks.
        for (int f = 0; f < 150; f++) begin
            int kind = int'($urandom_range(0, 7));
            if (kind == 3) byte_q.push_back(8'($urandom));
            push_frame(int'($urandom_range(0, 10)), kind);
        end
        for (int c = 0; c < 20000 && byte_q.size() > 0; c++) begin
            logic v = ($urandom_range(0, 3) != 0);
            logic a = ($urandom_range(0, 2) == 0);
            if (v) step(1'b1, byte_q.pop_front(), a, 1'b1);
            else   step(1'b0, 8'h00, a, 1'b1);
        end
        chk("rand_drained", 64'(byte_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
